// File: rtl/cgra_pkg.sv
// Shared CGRA bridge defaults: credit/idle limits, default slot layout and width helper.
package cgra_pkg;

  localparam int unsigned BRIDGE_MAX_OUTSTANDING = 2;
  localparam int unsigned BRIDGE_IDLE_HOLD       = 4;
  localparam int unsigned BRIDGE_ADDR_WIDTH      = 32;
  localparam int unsigned BRIDGE_DATA_WIDTH      = 32;

  // Default-width view of one port's request slot.
  typedef struct packed {
    logic [BRIDGE_ADDR_WIDTH-1:0]   addr;
    logic                           we;
    logic [BRIDGE_DATA_WIDTH/8-1:0] be;
    logic [BRIDGE_DATA_WIDTH-1:0]   wdata;
  } bridge_slot_t;

  // Counter width able to hold the values 0..max_val inclusive.
  function automatic int unsigned bridge_cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cgra_obi_port_slot.sv
// One bridge port: registered request slot, outstanding-credit counter, sticky spurious-rvalid flag.
// Optional stall counter under CGRA_BRIDGE_PERF_EN.
module cgra_obi_port_slot
  import cgra_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = BRIDGE_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = BRIDGE_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = BRIDGE_MAX_OUTSTANDING
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    tcdm_req_i,
  input  logic [ADDR_WIDTH-1:0]   tcdm_add_i,
  input  logic                    tcdm_wen_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_be_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_wdata_i,
  output logic                    tcdm_gnt_o,
  output logic                    obi_req_o,
  output logic [ADDR_WIDTH-1:0]   obi_addr_o,
  output logic                    obi_we_o,
  output logic [DATA_WIDTH/8-1:0] obi_be_o,
  output logic [DATA_WIDTH-1:0]   obi_wdata_o,
  input  logic                    obi_gnt_i,
  input  logic                    obi_rvalid_i,
  output logic                    drained_o,
  output logic                    err_o
`ifdef CGRA_BRIDGE_PERF_EN
  ,
  input  logic                    perf_clr_i,
  output logic [31:0]             perf_stall_o
`endif
);

  localparam int unsigned CntWidth = bridge_cnt_width(MAX_OUTSTANDING);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    we;
    logic [DATA_WIDTH/8-1:0] be;
    logic [DATA_WIDTH-1:0]   wdata;
  } slot_t;

  slot_t               slot_q;
  logic                slot_valid_q;
  logic [CntWidth-1:0] cnt_q;
  logic                err_q;
  logic                accept;
  logic                retire;

  // A full slot may only be refilled in the cycle it is handed to the bus.
  assign accept = tcdm_req_i && !flush_i && (cnt_q < CntMax) && (!slot_valid_q || obi_gnt_i);
  assign retire = obi_rvalid_i && (cnt_q != '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_q       <= '0;
      slot_valid_q <= 1'b0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        slot_valid_q <= 1'b1;
        slot_q       <= '{addr: tcdm_add_i, we: ~tcdm_wen_i, be: tcdm_be_i, wdata: tcdm_wdata_i};
      end else if (obi_gnt_i) begin
        slot_valid_q <= 1'b0;
      end
      if (accept && !retire) begin
        cnt_q <= cnt_q + CntWidth'(1);
      end else if (!accept && retire) begin
        cnt_q <= cnt_q - CntWidth'(1);
      end
      if (obi_rvalid_i && (cnt_q == '0)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign tcdm_gnt_o  = accept;
  assign obi_req_o   = slot_valid_q;
  assign obi_addr_o  = slot_q.addr;
  assign obi_we_o    = slot_q.we;
  assign obi_be_o    = slot_q.be;
  assign obi_wdata_o = slot_q.wdata;
  assign drained_o   = (cnt_q == '0);
  assign err_o       = err_q;

`ifdef CGRA_BRIDGE_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || perf_clr_i) begin
      perf_q <= '0;
    end else if (tcdm_req_i && !accept && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_o = perf_q;
`endif

endmodule

// File: rtl/cgra_obi_port_bridge.sv
// CGRA column TCDM ports to SoC OBI bridge with drain tracking for the array clock-gate enable.
// Optional per-port stall counters under CGRA_BRIDGE_PERF_EN.
module cgra_obi_port_bridge
  import cgra_pkg::*;
#(
  parameter int unsigned N_PORTS         = 4,
  parameter int unsigned ADDR_WIDTH      = BRIDGE_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = BRIDGE_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING = BRIDGE_MAX_OUTSTANDING,
  parameter int unsigned IDLE_HOLD       = BRIDGE_IDLE_HOLD
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              enable_i,
  input  logic                              flush_i,
  input  logic [N_PORTS-1:0]                tcdm_req_i,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]     tcdm_add_i,
  input  logic [N_PORTS-1:0]                tcdm_wen_i,
  input  logic [N_PORTS*DATA_WIDTH/8-1:0]   tcdm_be_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]     tcdm_wdata_i,
  output logic [N_PORTS-1:0]                tcdm_gnt_o,
  output logic [N_PORTS*DATA_WIDTH-1:0]     tcdm_rdata_o,
  output logic [N_PORTS-1:0]                tcdm_r_valid_o,
  output logic [N_PORTS-1:0]                obi_req_o,
  output logic [N_PORTS*ADDR_WIDTH-1:0]     obi_addr_o,
  output logic [N_PORTS-1:0]                obi_we_o,
  output logic [N_PORTS*DATA_WIDTH/8-1:0]   obi_be_o,
  output logic [N_PORTS*DATA_WIDTH-1:0]     obi_wdata_o,
  input  logic [N_PORTS-1:0]                obi_gnt_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]     obi_rdata_i,
  input  logic [N_PORTS-1:0]                obi_rvalid_i,
  output logic                              clk_en_o,
  output logic                              idle_o,
  output logic [N_PORTS-1:0]                err_o
`ifdef CGRA_BRIDGE_PERF_EN
  ,
  input  logic                              perf_clr_i,
  output logic [N_PORTS*32-1:0]             perf_stall_o
`endif
);

  localparam int unsigned BeWidth   = DATA_WIDTH / 8;
  localparam int unsigned IdleWidth = bridge_cnt_width(IDLE_HOLD);
  localparam logic [IdleWidth-1:0] IdleMax = IdleWidth'(IDLE_HOLD);

  logic [N_PORTS-1:0]   drained;
  logic [IdleWidth-1:0] idle_cnt_q;
  logic                 clk_en_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    cgra_obi_port_slot #(
      .ADDR_WIDTH      (ADDR_WIDTH),
      .DATA_WIDTH      (DATA_WIDTH),
      .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_slot (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (flush_i),
      .tcdm_req_i   (tcdm_req_i[p]),
      .tcdm_add_i   (tcdm_add_i[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .tcdm_wen_i   (tcdm_wen_i[p]),
      .tcdm_be_i    (tcdm_be_i[p*BeWidth +: BeWidth]),
      .tcdm_wdata_i (tcdm_wdata_i[p*DATA_WIDTH +: DATA_WIDTH]),
      .tcdm_gnt_o   (tcdm_gnt_o[p]),
      .obi_req_o    (obi_req_o[p]),
      .obi_addr_o   (obi_addr_o[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .obi_we_o     (obi_we_o[p]),
      .obi_be_o     (obi_be_o[p*BeWidth +: BeWidth]),
      .obi_wdata_o  (obi_wdata_o[p*DATA_WIDTH +: DATA_WIDTH]),
      .obi_gnt_i    (obi_gnt_i[p]),
      .obi_rvalid_i (obi_rvalid_i[p]),
      .drained_o    (drained[p]),
      .err_o        (err_o[p])
`ifdef CGRA_BRIDGE_PERF_EN
      ,
      .perf_clr_i   (perf_clr_i),
      .perf_stall_o (perf_stall_o[p*32 +: 32])
`endif
    );
  end

  // Responses are in order per port, so the return path is a plain pass-through.
  assign tcdm_rdata_o   = obi_rdata_i;
  assign tcdm_r_valid_o = obi_rvalid_i;

  assign idle_o = (&drained) && !(|tcdm_req_i);

  // The enable only drops once the drained state has held for IDLE_HOLD cycles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idle_cnt_q <= '0;
      clk_en_q   <= 1'b0;
    end else if (enable_i || !idle_o) begin
      idle_cnt_q <= '0;
      clk_en_q   <= 1'b1;
    end else if (idle_cnt_q != IdleMax) begin
      idle_cnt_q <= idle_cnt_q + IdleWidth'(1);
    end else begin
      clk_en_q <= 1'b0;
    end
  end

  assign clk_en_o = clk_en_q;

endmodule

// File: tb/tb_cgra_obi_port_bridge.sv
// Scoreboard bench for cgra_obi_port_bridge: directed vectors, queued OBI/response expectations.
module tb_cgra_obi_port_bridge;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            enable;
  logic            flush;
  logic [N-1:0]    tcdm_req;
  logic [N*AW-1:0] tcdm_add;
  logic [N-1:0]    tcdm_wen;
  logic [N*BW-1:0] tcdm_be;
  logic [N*DW-1:0] tcdm_wdata;
  logic [N-1:0]    tcdm_gnt;
  logic [N*DW-1:0] tcdm_rdata;
  logic [N-1:0]    tcdm_r_valid;
  logic [N-1:0]    obi_req;
  logic [N*AW-1:0] obi_addr;
  logic [N-1:0]    obi_we;
  logic [N*BW-1:0] obi_be;
  logic [N*DW-1:0] obi_wdata;
  logic [N-1:0]    obi_gnt;
  logic [N*DW-1:0] obi_rdata;
  logic [N-1:0]    obi_rvalid;
  logic            clk_en;
  logic            idle;
  logic [N-1:0]    err;
`ifdef CGRA_BRIDGE_PERF_EN
  logic            perf_clr = 1'b0;
  logic [N*32-1:0] perf_stall;
`endif

  always #5 clk = ~clk;

  cgra_obi_port_bridge #(
    .N_PORTS         (N),
    .ADDR_WIDTH      (AW),
    .DATA_WIDTH      (DW),
    .MAX_OUTSTANDING (2),
    .IDLE_HOLD       (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (enable),
    .flush_i        (flush),
    .tcdm_req_i     (tcdm_req),
    .tcdm_add_i     (tcdm_add),
    .tcdm_wen_i     (tcdm_wen),
    .tcdm_be_i      (tcdm_be),
    .tcdm_wdata_i   (tcdm_wdata),
    .tcdm_gnt_o     (tcdm_gnt),
    .tcdm_rdata_o   (tcdm_rdata),
    .tcdm_r_valid_o (tcdm_r_valid),
    .obi_req_o      (obi_req),
    .obi_addr_o     (obi_addr),
    .obi_we_o       (obi_we),
    .obi_be_o       (obi_be),
    .obi_wdata_o    (obi_wdata),
    .obi_gnt_i      (obi_gnt),
    .obi_rdata_i    (obi_rdata),
    .obi_rvalid_i   (obi_rvalid),
    .clk_en_o       (clk_en),
    .idle_o         (idle),
    .err_o          (err)
`ifdef CGRA_BRIDGE_PERF_EN
    ,
    .perf_clr_i     (perf_clr),
    .perf_stall_o   (perf_stall)
`endif
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          exp_obi[N][$];
  logic [DW-1:0] exp_rsp[N][$];
  int            total  = 0;
  int            passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic r, input logic [AW-1:0] a, input logic wen,
                         input logic [BW-1:0] be, input logic [DW-1:0] wd);
    tcdm_req[p]              = r;
    tcdm_add[p*AW +: AW]     = a;
    tcdm_wen[p]              = wen;
    tcdm_be[p*BW +: BW]      = be;
    tcdm_wdata[p*DW +: DW]   = wd;
  endtask

  task automatic push_obi(input int p, input logic [AW-1:0] a, input logic we,
                          input logic [BW-1:0] be, input logic [DW-1:0] wd);
    txn_t t;
    t.addr  = a;
    t.we    = we;
    t.be    = be;
    t.wdata = wd;
    exp_obi[p].push_back(t);
  endtask

  task automatic send_rsp(input int p, input logic [DW-1:0] d);
    obi_rvalid[p]          = 1'b1;
    obi_rdata[p*DW +: DW]  = d;
    exp_rsp[p].push_back(d);
  endtask

  // Monitor: every OBI handshake and every TCDM response pops one expectation.
  always @(negedge clk) begin : monitor
    txn_t          e;
    logic [DW-1:0] r;
    if (rst === 1'b0) begin
      for (int p = 0; p < N; p++) begin
        if (obi_req[p] === 1'b1 && obi_gnt[p] === 1'b1) begin
          if (exp_obi[p].size() == 0) begin
            chk($sformatf("obi_unexpected_p%0d", p), 64'(obi_req[p]), 64'd0);
          end else begin
            e = exp_obi[p].pop_front();
            chk($sformatf("obi_addr_p%0d", p), 64'(obi_addr[p*AW +: AW]), 64'(e.addr));
            chk($sformatf("obi_we_p%0d", p), 64'(obi_we[p]), 64'(e.we));
            chk($sformatf("obi_be_p%0d", p), 64'(obi_be[p*BW +: BW]), 64'(e.be));
            chk($sformatf("obi_wdata_p%0d", p), 64'(obi_wdata[p*DW +: DW]), 64'(e.wdata));
          end
        end
        if (tcdm_r_valid[p] === 1'b1) begin
          if (exp_rsp[p].size() == 0) begin
            chk($sformatf("rsp_unexpected_p%0d", p), 64'(tcdm_r_valid[p]), 64'd0);
          end else begin
            r = exp_rsp[p].pop_front();
            chk($sformatf("rsp_rdata_p%0d", p), 64'(tcdm_rdata[p*DW +: DW]), 64'(r));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d passed=%0d", total, passed);
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    enable     = 1'b1;
    flush      = 1'b0;
    tcdm_req   = '0;
    tcdm_add   = '0;
    tcdm_wen   = '1;
    tcdm_be    = '0;
    tcdm_wdata = '0;
    obi_gnt    = '1;
    obi_rdata  = '0;
    obi_rvalid = '0;

    // Reset state
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("rst_obi_req", 64'(obi_req), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_clk_en", 64'(clk_en), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    @(negedge clk);
    chk("enable_clk_en", 64'(clk_en), 64'd1);

    // 1: single read on port 0
    next_cycle();
    set_req(0, 1'b1, 32'h100, 1'b1, 4'hF, 32'h0);
    push_obi(0, 32'h100, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t1_gnt", 64'(tcdm_gnt[0]), 64'd1);
    chk("t1_req_before", 64'(obi_req[0]), 64'd0);
    next_cycle();
    tcdm_req[0] = 1'b0;
    @(negedge clk);
    chk("t1_req_lat1", 64'(obi_req[0]), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("t1_req_one_cycle", 64'(obi_req[0]), 64'd0);
    next_cycle();
    send_rsp(0, 32'hDEADBEEF);
    next_cycle();
    obi_rvalid[0] = 1'b0;
    @(negedge clk);
    chk("t1_idle", 64'(idle), 64'd1);

    // 2: credit limit on port 1
    next_cycle();
    set_req(1, 1'b1, 32'h200, 1'b1, 4'hF, 32'h0);
    push_obi(1, 32'h200, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t2_gnt_a", 64'(tcdm_gnt[1]), 64'd1);
    next_cycle();
    set_req(1, 1'b1, 32'h204, 1'b1, 4'hF, 32'h0);
    push_obi(1, 32'h204, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t2_gnt_b", 64'(tcdm_gnt[1]), 64'd1);
    next_cycle();
    set_req(1, 1'b1, 32'h208, 1'b1, 4'hF, 32'h0);
    @(negedge clk);
    chk("t2_refuse_c0", 64'(tcdm_gnt[1]), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("t2_refuse_c1", 64'(tcdm_gnt[1]), 64'd0);
    next_cycle();
    send_rsp(1, 32'hA1A1A1A1);
    @(negedge clk);
    chk("t2_refuse_rvalid", 64'(tcdm_gnt[1]), 64'd0);
    next_cycle();
    obi_rvalid[1] = 1'b0;
    push_obi(1, 32'h208, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t2_gnt_after", 64'(tcdm_gnt[1]), 64'd1);
    next_cycle();
    tcdm_req[1] = 1'b0;
    next_cycle();
    send_rsp(1, 32'hA2A2A2A2);
    next_cycle();
    send_rsp(1, 32'hA3A3A3A3);
    next_cycle();
    obi_rvalid[1] = 1'b0;
    @(negedge clk);
    chk("t2_idle", 64'(idle), 64'd1);

    // 3: write stalled by the bus on port 3
    next_cycle();
    obi_gnt[3] = 1'b0;
    set_req(3, 1'b1, 32'h40, 1'b0, 4'hF, 32'h12345678);
    push_obi(3, 32'h40, 1'b1, 4'hF, 32'h12345678);
    @(negedge clk);
    chk("t3_gnt", 64'(tcdm_gnt[3]), 64'd1);
    next_cycle();
    set_req(3, 1'b1, 32'h44, 1'b1, 4'h3, 32'h9);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_hold_gnt", 64'(tcdm_gnt[3]), 64'd0);
      chk("t3_hold_req", 64'(obi_req[3]), 64'd1);
      chk("t3_hold_addr", 64'(obi_addr[3*AW +: AW]), 64'h40);
      chk("t3_hold_we", 64'(obi_we[3]), 64'd1);
      chk("t3_hold_wdata", 64'(obi_wdata[3*DW +: DW]), 64'h12345678);
      next_cycle();
    end
    tcdm_req[3] = 1'b0;
    obi_gnt[3]  = 1'b1;
    next_cycle();
    send_rsp(3, 32'h0);
    next_cycle();
    obi_rvalid[3] = 1'b0;
    @(negedge clk);
    chk("t3_idle", 64'(idle), 64'd1);

    // 4: spurious response on port 2
    next_cycle();
    send_rsp(2, 32'h55);
    next_cycle();
    obi_rvalid[2] = 1'b0;
    @(negedge clk);
    chk("t4_err", 64'(err), 64'b0100);
    chk("t4_idle", 64'(idle), 64'd1);

    // 5: clock-enable drain with flush
    next_cycle();
    set_req(0, 1'b1, 32'h300, 1'b1, 4'hF, 32'h0);
    push_obi(0, 32'h300, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t5_gnt", 64'(tcdm_gnt[0]), 64'd1);
    next_cycle();
    tcdm_req[0] = 1'b0;
    enable      = 1'b0;
    flush       = 1'b1;
    set_req(1, 1'b1, 32'h500, 1'b1, 4'hF, 32'h0);
    @(negedge clk);
    chk("t5_flush_gnt", 64'(tcdm_gnt[1]), 64'd0);
    chk("t5_clk_en_a", 64'(clk_en), 64'd1);
    next_cycle();
    tcdm_req[1] = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", 64'(idle), 64'd0);
    chk("t5_clk_en_b", 64'(clk_en), 64'd1);
    next_cycle();
    @(negedge clk);
    chk("t5_clk_en_c", 64'(clk_en), 64'd1);
    next_cycle();
    send_rsp(0, 32'h0BADF00D);
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("t5_drain_k%0d", k), 64'(clk_en), (k < 6) ? 64'd1 : 64'd0);
      next_cycle();
      if (k == 0) obi_rvalid[0] = 1'b0;
    end
    enable = 1'b1;
    flush  = 1'b0;
    @(negedge clk);
    chk("t5_reenable_same", 64'(clk_en), 64'd0);
    next_cycle();
    @(negedge clk);
    chk("t5_reenable_next", 64'(clk_en), 64'd1);

    // 6: reset mid-transaction
    next_cycle();
    set_req(0, 1'b1, 32'h600, 1'b1, 4'hF, 32'h0);
    push_obi(0, 32'h600, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    chk("t6_gnt_a", 64'(tcdm_gnt[0]), 64'd1);
    next_cycle();
    set_req(0, 1'b1, 32'h604, 1'b1, 4'hF, 32'h0);
    @(negedge clk);
    chk("t6_gnt_b", 64'(tcdm_gnt[0]), 64'd1);
    next_cycle();
    tcdm_req[0] = 1'b0;
    obi_gnt[0]  = 1'b0;
    @(negedge clk);
    chk("t6_pending_req", 64'(obi_req[0]), 64'd1);
    chk("t6_pending_addr", 64'(obi_addr[0 +: AW]), 64'h604);
    chk("t6_err_sticky", 64'(err), 64'b0100);
    chk("t6_busy", 64'(idle), 64'd0);
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_req", 64'(obi_req), 64'd0);
    chk("t6_rst_idle", 64'(idle), 64'd1);
    chk("t6_rst_clk_en", 64'(clk_en), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    next_cycle();
    obi_gnt[0] = 1'b1;
    @(negedge clk);
    chk("t6_clk_en_back", 64'(clk_en), 64'd1);

    for (int p = 0; p < N; p++) begin
      chk($sformatf("sb_drained_p%0d", p), 64'(exp_obi[p].size() + exp_rsp[p].size()), 64'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
